// File: rtl/pet_pkg.sv
// pet_pkg: shared constants, need bundle and saturating helpers
// for the pet_needs virtual-pet block.
package pet_pkg;

  localparam logic [1:0] ACT_PLAY  = 2'd0;
  localparam logic [1:0] ACT_EAT   = 2'd1;
  localparam logic [1:0] ACT_SLEEP = 2'd2;
  localparam logic [1:0] ACT_HEAL  = 2'd3;

  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_SICK  = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  localparam logic [7:0] NEED_MAX   = 8'd100;
  localparam logic [7:0] SICK_LEVEL = 8'd20;

`ifdef PET_MEDICINE_EN
  localparam logic [2:0] MEDS_RST  = 3'd3;
  localparam logic [2:0] MEDS_MAX  = 3'd7;
  localparam logic [5:0] MEDS_LAST = 6'd63;
`endif

  typedef struct packed {
    logic [6:0] food;
    logic [6:0] fun;
    logic [6:0] rest;
    logic [6:0] life;
  } needs_t;

  localparam needs_t NEEDS_RST = '{
    food: 7'd100,
    fun:  7'd100,
    rest: 7'd100,
    life: 7'd100
  };

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, NEED_MAX}) ? NEED_MAX : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a < b) ? 8'd0 : a - b;
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// pet_tick_gen: free-running prescaler, one-cycle tick at the
// terminal count TICK_CYCLES-1.
module pet_tick_gen
  import pet_pkg::*;
#(
  parameter int TICK_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/pet_needs.sv
// pet_needs: tick-driven food/fun/rest decay, life tracking, health FSM
// and action handshake. Define PET_MEDICINE_EN for the meds supply.
module pet_needs
  import pet_pkg::*;
#(
  parameter int TICK_CYCLES    = 5000000,
  parameter int DECAY_TICKS    = 1,
  parameter int ACTION_GAIN    = 20,
  parameter int COOLDOWN_TICKS = 2,
  parameter int LIFE_PLUS      = 70,
  parameter int LIFE_MINUS     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       act_valid,
  input  logic [1:0] act_code,
  output logic       act_ready,
  output logic [6:0] food,
  output logic [6:0] fun,
  output logic [6:0] rest,
  output logic [6:0] life,
  output logic       disease,
  output logic       death,
`ifdef PET_MEDICINE_EN
  output logic [2:0] meds,
`endif
  output logic       tick
);

  localparam int DW =
    (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int CW = $clog2(COOLDOWN_TICKS + 2);

  localparam logic [DW-1:0] DLAST = DW'(DECAY_TICKS - 1);
  localparam logic [CW-1:0] COOL  = CW'(COOLDOWN_TICKS);
  localparam logic [7:0]    GAIN  = 8'(ACTION_GAIN);
  localparam logic [7:0]    HALF  = 8'(ACTION_GAIN / 2);
  localparam logic [7:0]    LP    = 8'(LIFE_PLUS);
  localparam logic [7:0]    LM    = 8'(LIFE_MINUS);

  needs_t        r_nd;
  logic [1:0]    r_state;
  logic          r_disease;
  logic          r_death;
  logic [CW-1:0] r_cool;
  logic [DW-1:0] r_dcnt;

  logic       w_tick;
  logic       w_dead;
  logic       w_upd;
  logic       w_decay;
  logic       w_rdy_base;
  logic       w_ready;
  logic       w_acc;
  logic       w_play;
  logic       w_eat;
  logic       w_sleep;
  logic       w_heal;
  logic [1:0] w_state;

  logic [7:0] w_f0;
  logic [7:0] w_u0;
  logic [7:0] w_r0;
  logic [7:0] w_l0;
  logic [7:0] w_plus;
  logic [7:0] w_minus;
  logic [7:0] w_lsum;
  logic [7:0] w_lnet;
  logic [7:0] w_lclip;
  logic [7:0] w_food;
  logic [7:0] w_fun;
  logic [7:0] w_rest;
  logic [7:0] w_life;

  pet_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  assign w_dead  = (r_state == ST_DEAD);
  assign w_upd   = w_tick && !w_dead;
  assign w_decay = w_upd && (r_dcnt == DLAST);

  assign w_play  = (act_code == ACT_PLAY);
  assign w_eat   = (act_code == ACT_EAT);
  assign w_sleep = (act_code == ACT_SLEEP);
  assign w_heal  = (act_code == ACT_HEAL);

  assign w_rdy_base = !w_dead && (r_cool == '0);
  assign w_acc      = act_valid && w_ready;

  assign w_f0 = {1'b0, r_nd.food};
  assign w_u0 = {1'b0, r_nd.fun};
  assign w_r0 = {1'b0, r_nd.rest};
  assign w_l0 = {1'b0, r_nd.life};

  // Life moves on pre-tick needs; clamp only after both terms.
  assign w_plus =
    {7'd0, w_f0 >= LP} +
    {7'd0, w_u0 >= LP} +
    {7'd0, w_r0 >= LP};
  assign w_minus =
    {7'd0, w_f0 <= LM} +
    {7'd0, w_u0 <= LM} +
    {7'd0, w_r0 <= LM};
  assign w_lsum  = w_l0 + w_plus;
  assign w_lnet  =
    (w_lsum < w_minus) ? 8'd0 : w_lsum - w_minus;
  assign w_lclip =
    (w_lnet > NEED_MAX) ? NEED_MAX : w_lnet;

  // Tick effects land first, the accepted action on top.
  always_comb begin
    w_food = w_f0;
    w_fun  = w_u0;
    w_rest = w_r0;
    w_life = w_l0;
    if (w_decay) begin
      w_food = sat_sub(w_food, 8'd1);
      w_fun  = sat_sub(w_fun, 8'd1);
      w_rest = sat_sub(w_rest, 8'd1);
    end
    if (w_upd) begin
      w_life = w_lclip;
    end
    if (w_acc) begin
      unique case (1'b1)
        w_play: begin
          w_fun  = sat_add(w_fun, GAIN);
          w_rest = sat_sub(w_rest, HALF);
        end
        w_eat:   w_food = sat_add(w_food, GAIN);
        w_sleep: w_rest = sat_add(w_rest, GAIN);
        w_heal: begin
          if (r_state == ST_SICK) begin
            w_life = sat_add(w_life, GAIN);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state = r_state;
    if (w_dead || (w_life == 8'd0)) begin
      w_state = ST_DEAD;
    end else if (w_life <= SICK_LEVEL) begin
      w_state = ST_SICK;
    end else begin
      w_state = ST_ALIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nd      <= NEEDS_RST;
      r_state   <= ST_ALIVE;
      r_disease <= 1'b0;
      r_death   <= 1'b0;
      r_cool    <= '0;
      r_dcnt    <= '0;
    end else begin
      r_nd.food <= 7'(w_food);
      r_nd.fun  <= 7'(w_fun);
      r_nd.rest <= 7'(w_rest);
      r_nd.life <= 7'(w_life);
      r_state   <= w_state;
      r_disease <= (w_state == ST_SICK);
      r_death   <= (w_state == ST_DEAD);
      if (w_acc) begin
        r_cool <= COOL;
      end else if (w_tick && (r_cool != '0)) begin
        r_cool <= r_cool - CW'(1);
      end
      if (w_tick) begin
        r_dcnt <= (r_dcnt == DLAST) ?
          '0 : r_dcnt + DW'(1);
      end
    end
  end

`ifdef PET_MEDICINE_EN
  logic [2:0] r_meds;
  logic [5:0] r_mcnt;
  logic [2:0] w_meds;
  logic       w_med_inc;

  assign w_ready =
    w_rdy_base && !(w_heal && (r_meds == 3'd0));
  assign w_med_inc = w_tick && (r_mcnt == MEDS_LAST);

  always_comb begin
    w_meds = r_meds;
    if (w_acc && w_heal) begin
      w_meds = w_meds - 3'd1;
    end
    if (w_med_inc && (w_meds != MEDS_MAX)) begin
      w_meds = w_meds + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meds <= MEDS_RST;
      r_mcnt <= 6'd0;
    end else begin
      r_meds <= w_meds;
      if (w_tick) begin
        r_mcnt <= r_mcnt + 6'd1;
      end
    end
  end

  assign meds = r_meds;
`else
  assign w_ready = w_rdy_base;
`endif

  assign act_ready = w_ready;
  assign food      = r_nd.food;
  assign fun       = r_nd.fun;
  assign rest      = r_nd.rest;
  assign life      = r_nd.life;
  assign disease   = r_disease;
  assign death     = r_death;
  assign tick      = w_tick;

endmodule
